// File: rtl/sync_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_pkg : shared limits and helpers for the sync_debounce block
// Rev 1.0
// ---------------------------------------------------------------------------
package sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int DEBOUNCE_MAX    = 65535;

  // Ceiling log2; callers pass value >= 2, so the result is at least 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage : sync_pkg
`default_nettype wire

// File: rtl/sync_debounce_ch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_debounce_ch : one channel - sync chain, persistence counter, level reg,
// optional edge pulses (SYNC_EDGE_DETECT_EN).   Rev 1.0
// ---------------------------------------------------------------------------
module sync_debounce_ch
  import sync_pkg::*;
#(
  parameter int   STAGES          = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic INIT_VAL        = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic level_o,
  output logic busy_o
`ifdef SYNC_EDGE_DETECT_EN
  ,
  output logic rise_o,
  output logic fall_o
`endif
);

  localparam int               CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              level_q;
  logic              level_d;
  logic              sync_bit;
  logic              accept;

  assign sync_bit = sync_q[STAGES-1];

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], in};
  end

  // Counter only runs while the synchronised value disagrees with the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (sync_bit == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      accept  = 1'b1;
      level_d = sync_bit;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= {STAGES{INIT_VAL}};
      cnt_q   <= '0;
      level_q <= INIT_VAL;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  assign busy_o  = |cnt_q;

`ifdef SYNC_EDGE_DETECT_EN
  logic rise_q;
  logic rise_d;
  logic fall_q;
  logic fall_d;

  always_comb begin
    rise_d = accept & sync_bit;
    fall_d = accept & ~sync_bit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule : sync_debounce_ch
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_debounce : WIDTH-channel synchroniser + debounce filter; edge pulses
// rise_o/fall_o exist only when SYNC_EDGE_DETECT_EN is defined.   Rev 1.0
// ---------------------------------------------------------------------------
module sync_debounce
  import sync_pkg::*;
#(
  parameter int               WIDTH           = 1,
  parameter int               STAGES          = 2,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] INIT_VAL        = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] busy_o
`ifdef SYNC_EDGE_DETECT_EN
  ,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
`endif
);

  if ((STAGES < SYNC_STAGES_MIN) || (STAGES > SYNC_STAGES_MAX)) begin : g_bad_stages
    $error("sync_debounce: STAGES=%0d outside %0d..%0d", STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end

  if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > DEBOUNCE_MAX)) begin : g_bad_debounce
    $error("sync_debounce: DEBOUNCE_CYCLES=%0d outside 1..%0d", DEBOUNCE_CYCLES, DEBOUNCE_MAX);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_debounce_ch #(
      .STAGES          (STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INIT_VAL        (INIT_VAL[i])
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .in      (in[i]),
      .level_o (level_o[i]),
      .busy_o  (busy_o[i])
`ifdef SYNC_EDGE_DETECT_EN
      ,
      .rise_o  (rise_o[i]),
      .fall_o  (fall_o[i])
`endif
    );
  end

endmodule : sync_debounce
`default_nettype wire

// File: tb/tb_sync_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sync_debounce : directed bench for sync_debounce (four parameter sets)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sync_debounce;

  logic       clk;
  logic       reset_n;
  int         n_cmp;
  int         n_fail;

  logic       in_a, level_a, busy_a;
  logic [3:0] in_w, level_w, busy_w;
  logic       in_c, level_c, busy_c;
  logic       in_i, level_i, busy_i;
`ifdef SYNC_EDGE_DETECT_EN
  logic       rise_a, fall_a, rise_c, fall_c, rise_i, fall_i;
  logic [3:0] rise_w, fall_w;
`endif

  sync_debounce dut_a (
    .clk(clk), .reset_n(reset_n), .in(in_a), .level_o(level_a), .busy_o(busy_a)
`ifdef SYNC_EDGE_DETECT_EN
    , .rise_o(rise_a), .fall_o(fall_a)
`endif
  );

  sync_debounce #(.WIDTH(4)) dut_w (
    .clk(clk), .reset_n(reset_n), .in(in_w), .level_o(level_w), .busy_o(busy_w)
`ifdef SYNC_EDGE_DETECT_EN
    , .rise_o(rise_w), .fall_o(fall_w)
`endif
  );

  sync_debounce #(.STAGES(3), .DEBOUNCE_CYCLES(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .in(in_c), .level_o(level_c), .busy_o(busy_c)
`ifdef SYNC_EDGE_DETECT_EN
    , .rise_o(rise_c), .fall_o(fall_c)
`endif
  );

  sync_debounce #(.INIT_VAL(1'b1)) dut_i (
    .clk(clk), .reset_n(reset_n), .in(in_i), .level_o(level_i), .busy_o(busy_i)
`ifdef SYNC_EDGE_DETECT_EN
    , .rise_o(rise_i), .fall_o(fall_i)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit k of each pattern applies to the k-th edge of the sequence.
  task automatic run_a(input string tag, input int n, input logic [15:0] in_pat,
                       input logic [15:0] lvl_pat, input logic [15:0] busy_pat,
                       input logic [15:0] rise_pat, input logic [15:0] fall_pat);
    for (int k = 0; k < n; k++) begin
      in_a = in_pat[k];
      tick();
      check($sformatf("%s/level@%0d", tag, k), {31'd0, level_a}, {31'd0, lvl_pat[k]});
      check($sformatf("%s/busy@%0d", tag, k), {31'd0, busy_a}, {31'd0, busy_pat[k]});
`ifdef SYNC_EDGE_DETECT_EN
      check($sformatf("%s/rise@%0d", tag, k), {31'd0, rise_a}, {31'd0, rise_pat[k]});
      check($sformatf("%s/fall@%0d", tag, k), {31'd0, fall_a}, {31'd0, fall_pat[k]});
`else
      if ((rise_pat[k] | fall_pat[k]) === 1'bx) $display("edge pattern undefined at %0d", k);
`endif
    end
  endtask

  initial begin
    logic [3:0] exp_lvl_w;
    logic [3:0] exp_busy_w;
    n_cmp   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    in_a    = 1'b0;
    in_w    = 4'b0000;
    in_c    = 1'b0;
    in_i    = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst/level_a", {31'd0, level_a}, 32'd0);
    check("rst/busy_a", {31'd0, busy_a}, 32'd0);
    check("rst/level_w", {28'd0, level_w}, 32'd0);
    check("rst/busy_w", {28'd0, busy_w}, 32'd0);
    check("rst/level_i", {31'd0, level_i}, 32'd1);
    reset_n = 1'b1;

    // Default channel: rise then fall, each 6 edges from capture
    run_a("rise", 8, 16'h00FF, 16'b1110_0000, 16'b0001_1100, 16'b0010_0000, 16'h0000);
    run_a("fall", 8, 16'h0000, 16'b0001_1111, 16'b0001_1100, 16'h0000, 16'b0010_0000);

    // Glitches: 3-cycle pulse rejected, 4-cycle pulse accepted
    run_a("gl3", 8, 16'b0000_0111, 16'h0000, 16'b0001_1100, 16'h0000, 16'h0000);
    run_a("gl4", 12, 16'b0000_0000_1111, 16'b0001_1110_0000, 16'b0001_1101_1100,
          16'b0000_0010_0000, 16'b0010_0000_0000);

    // Reset mid-count: discard count, then full latency again
    run_a("mid", 4, 16'h000F, 16'h0000, 16'b1100, 16'h0000, 16'h0000);
    reset_n = 1'b0;
    #2;
    check("mid/async_busy", {31'd0, busy_a}, 32'd0);
    check("mid/async_level", {31'd0, level_a}, 32'd0);
    tick();
    tick();
    check("mid/held_level", {31'd0, level_a}, 32'd0);
    reset_n = 1'b1;
    run_a("post", 8, 16'h00FF, 16'b1110_0000, 16'b0001_1100, 16'b0010_0000, 16'h0000);

    // Reset while level is 1 and a fall is being counted: level snaps to INIT
    run_a("down", 4, 16'h0000, 16'b1111, 16'b1100, 16'h0000, 16'h0000);
    reset_n = 1'b0;
    #2;
    check("down/async_level", {31'd0, level_a}, 32'd0);
    check("down/async_busy", {31'd0, busy_a}, 32'd0);
    tick();
    reset_n = 1'b1;
    run_a("idle", 6, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    // Four channels: bits 0/2 together, bit 1 two cycles later
    for (int k = 0; k < 10; k++) begin
      if (k == 0) in_w = 4'b0101;
      if (k == 2) in_w = 4'b0111;
      tick();
      exp_lvl_w  = (k >= 7) ? 4'b0111 : ((k >= 5) ? 4'b0101 : 4'b0000);
      exp_busy_w = ((k >= 2 && k <= 4) ? 4'b0101 : 4'b0000) |
                   ((k >= 4 && k <= 6) ? 4'b0010 : 4'b0000);
      check($sformatf("w4/level@%0d", k), {28'd0, level_w}, {28'd0, exp_lvl_w});
      check($sformatf("w4/busy@%0d", k), {28'd0, busy_w}, {28'd0, exp_busy_w});
    end

    // STAGES=3, DEBOUNCE_CYCLES=1: 4-edge latency, never busy
    in_c = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("c/rise_level@%0d", k), {31'd0, level_c}, (k >= 3) ? 32'd1 : 32'd0);
      check($sformatf("c/rise_busy@%0d", k), {31'd0, busy_c}, 32'd0);
    end
    in_c = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("c/fall_level@%0d", k), {31'd0, level_c}, (k >= 3) ? 32'd0 : 32'd1);
      check($sformatf("c/fall_busy@%0d", k), {31'd0, busy_c}, 32'd0);
    end

    // INIT_VAL=1 channel held at 1 through every reset: no change, no pulse
    check("init/level", {31'd0, level_i}, 32'd1);
    check("init/busy", {31'd0, busy_i}, 32'd0);
`ifdef SYNC_EDGE_DETECT_EN
    check("init/rise", {31'd0, rise_i}, 32'd0);
    check("init/fall", {31'd0, fall_i}, 32'd0);
`endif
    in_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("init/fall_level@%0d", k), {31'd0, level_i}, (k >= 5) ? 32'd0 : 32'd1);
      check($sformatf("init/fall_busy@%0d", k), {31'd0, busy_i},
            (k >= 2 && k <= 4) ? 32'd1 : 32'd0);
`ifdef SYNC_EDGE_DETECT_EN
      check($sformatf("init/fall_pulse@%0d", k), {31'd0, fall_i}, (k == 5) ? 32'd1 : 32'd0);
      check($sformatf("init/rise_pulse@%0d", k), {31'd0, rise_i}, 32'd0);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_sync_debounce
`default_nettype wire
